serial_alu_seq: RTL and testbench

SERIAL_ALU_SEQ -- requirements
Module: serial_alu_seq

---
 rtl/alu_pkg.sv | 26 ++
 rtl/serial_shift_reg.sv | 32 +++
 rtl/serial_alu_seq.sv | 154 +++++++++++++++
 tb/tb_serial_alu_seq.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared constants for the bit-serial ALU sequencer: op codes, FSM states, width default.
package alu_pkg;

  localparam int unsigned ALU_WIDTH_DEFAULT = 32;

  localparam logic [2:0] OP_ADD     = 3'b000;
  localparam logic [2:0] OP_ADD_ALT = 3'b001;
  localparam logic [2:0] OP_SUB     = 3'b010;
  localparam logic [2:0] OP_XOR     = 3'b011;
  localparam logic [2:0] OP_AND     = 3'b100;
  localparam logic [2:0] OP_NAND    = 3'b101;
  localparam logic [2:0] OP_NOR     = 3'b110;
  localparam logic [2:0] OP_OR      = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } alu_state_t;

  // Overflow is only meaningful for the carry-chain ops.
  function automatic logic is_arith(input logic [2:0] op);
    return (op == OP_ADD) || (op == OP_ADD_ALT) || (op == OP_SUB);
  endfunction

endpackage

// File: rtl/serial_shift_reg.sv
// Parallel-load register that shifts right (LSB out first), inserting ser_i at the MSB.
module serial_shift_reg #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load_i,
  input  logic [WIDTH-1:0] load_data_i,
  input  logic             shift_i,
  input  logic             ser_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] sr_q;

  if (WIDTH > 1) begin : g_wide
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)       sr_q <= '0;
      else if (load_i)  sr_q <= load_data_i;
      else if (shift_i) sr_q <= {ser_i, sr_q[WIDTH-1:1]};
    end
  end else begin : g_single
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)       sr_q <= '0;
      else if (load_i)  sr_q <= load_data_i;
      else if (shift_i) sr_q <= ser_i;
    end
  end

  assign q_o = sr_q;

endmodule

// File: rtl/serial_alu_seq.sv
// Sequencer driving an external 1-bit ALU slice over WIDTH cycles, LSB first,
// collecting the result and carry/zero/overflow flags.
module serial_alu_seq
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = ALU_WIDTH_DEFAULT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] opa,
  input  logic [WIDTH-1:0] opb,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             carry_out,
  output logic             zero,
  output logic             overflow,
  output logic             slice_a,
  output logic             slice_b,
  output logic             slice_c,
  output logic             slice_z0,
  output logic [2:0]       slice_s,
  input  logic             slice_out,
  input  logic             slice_carry,
  input  logic             slice_z1
);

  localparam int unsigned     CW   = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0]   LAST = CW'(WIDTH - 1);

  alu_state_t       state_q, state_d;
  logic [CW-1:0]    cnt_q;
  logic [2:0]       op_q;
  logic             carry_q;
  logic             sticky_q;
  logic [WIDTH-1:0] result_q;
  logic             carry_out_q;
  logic             zero_q;
  logic             overflow_q;

  logic             running;
  logic             accept;
  logic             last;
  logic [WIDTH-1:0] a_sr, b_sr;
  logic [WIDTH-2:0] res_sr;
  logic             unused_sr_bits;

  assign running = (state_q == ST_RUN);
  assign accept  = start && !running;
  assign last    = running && (cnt_q == LAST);

  serial_shift_reg #(.WIDTH(WIDTH)) u_opa_sr (
    .clk         (clk),
    .rst_n       (rst_n),
    .load_i      (accept),
    .load_data_i (opa),
    .shift_i     (running),
    .ser_i       (1'b0),
    .q_o         (a_sr)
  );

  serial_shift_reg #(.WIDTH(WIDTH)) u_opb_sr (
    .clk         (clk),
    .rst_n       (rst_n),
    .load_i      (accept),
    .load_data_i (opb),
    .shift_i     (running),
    .ser_i       (1'b0),
    .q_o         (b_sr)
  );

  // One bit short: the final slice bit is merged directly into result_q on the last cycle.
  serial_shift_reg #(.WIDTH(WIDTH - 1)) u_res_sr (
    .clk         (clk),
    .rst_n       (rst_n),
    .load_i      (accept),
    .load_data_i ('0),
    .shift_i     (running),
    .ser_i       (slice_out),
    .q_o         (res_sr)
  );

  assign unused_sr_bits = ^{a_sr[WIDTH-1:1], b_sr[WIDTH-1:1]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: if (start) state_d = ST_RUN;
      ST_RUN:  if (last)  state_d = ST_DONE;
      ST_DONE: state_d = start ? ST_RUN : ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q       <= '0;
      op_q        <= '0;
      carry_q     <= 1'b0;
      sticky_q    <= 1'b0;
      result_q    <= '0;
      carry_out_q <= 1'b0;
      zero_q      <= 1'b0;
      overflow_q  <= 1'b0;
    end else begin
      if (accept) begin
        cnt_q    <= '0;
        op_q     <= op;
        carry_q  <= op[1];
        sticky_q <= 1'b0;
      end else if (running) begin
        if (!last) cnt_q <= cnt_q + 1'b1;
        carry_q  <= slice_carry;
        sticky_q <= slice_z1;
      end
      if (last) begin
        result_q    <= {slice_out, res_sr};
        carry_out_q <= slice_carry;
        zero_q      <= ~slice_z1;
        overflow_q  <= is_arith(op_q) & (carry_q ^ slice_carry);
      end
    end
  end

  always_comb begin
    slice_a  = 1'b0;
    slice_b  = 1'b0;
    slice_c  = 1'b0;
    slice_z0 = 1'b0;
    slice_s  = 3'b000;
    if (running) begin
      slice_a  = a_sr[0];
      slice_b  = b_sr[0];
      slice_c  = carry_q;
      slice_z0 = sticky_q;
      slice_s  = op_q;
    end
  end

  assign busy      = running;
  assign done      = (state_q == ST_DONE);
  assign result    = result_q;
  assign carry_out = carry_out_q;
  assign zero      = zero_q;
  assign overflow  = overflow_q;

endmodule

// File: tb/tb_serial_alu_seq.sv
// Bench for serial_alu_seq: behavioural 1-bit slice plus word-level reference model.
module tb_serial_alu_seq;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [2:0]   op = 3'b000;
  logic [W-1:0] opa = '0, opb = '0;
  logic         busy, done, carry_out, zero, overflow;
  logic [W-1:0] result;
  logic         slice_a, slice_b, slice_c, slice_z0;
  logic [2:0]   slice_s;
  logic         slice_out, slice_carry, slice_z1;

  int n_assert = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  serial_alu_seq #(.WIDTH(W)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .op          (op),
    .opa         (opa),
    .opb         (opb),
    .busy        (busy),
    .done        (done),
    .result      (result),
    .carry_out   (carry_out),
    .zero        (zero),
    .overflow    (overflow),
    .slice_a     (slice_a),
    .slice_b     (slice_b),
    .slice_c     (slice_c),
    .slice_z0    (slice_z0),
    .slice_s     (slice_s),
    .slice_out   (slice_out),
    .slice_carry (slice_carry),
    .slice_z1    (slice_z1)
  );

  // Behavioural slice: full adder for add/sub (b inverted for sub), plain gates otherwise.
  always_comb begin
    logic [1:0] s;
    s = 2'b00;
    slice_out   = 1'b0;
    slice_carry = 1'b0;
    case (slice_s)
      3'b000, 3'b001: begin s = slice_a + slice_b + slice_c;  slice_out = s[0]; slice_carry = s[1]; end
      3'b010:         begin s = slice_a + !slice_b + slice_c; slice_out = s[0]; slice_carry = s[1]; end
      3'b011:  slice_out = slice_a ^ slice_b;
      3'b100:  slice_out = slice_a & slice_b;
      3'b101:  slice_out = ~(slice_a & slice_b);
      3'b110:  slice_out = ~(slice_a | slice_b);
      default: slice_out = slice_a | slice_b;
    endcase
    slice_z1 = slice_z0 | slice_out;
  end

  typedef struct {
    logic [W-1:0] res;
    logic         c;
    logic         z;
    logic         v;
  } exp_t;

  function automatic exp_t model(input logic [2:0] o, input logic [W-1:0] a, input logic [W-1:0] b);
    exp_t e;
    logic [W:0] wide;
    e.c = 1'b0;
    e.v = 1'b0;
    case (o)
      3'b000, 3'b001: begin
        wide  = {1'b0, a} + {1'b0, b};
        e.res = wide[W-1:0];
        e.c   = wide[W];
        e.v   = (a[W-1] == b[W-1]) && (e.res[W-1] != a[W-1]);
      end
      3'b010: begin
        wide  = {1'b0, a} + {1'b0, ~b} + 1;
        e.res = wide[W-1:0];
        e.c   = wide[W];
        e.v   = (a[W-1] != b[W-1]) && (e.res[W-1] != a[W-1]);
      end
      3'b011:  e.res = a ^ b;
      3'b100:  e.res = a & b;
      3'b101:  e.res = ~(a & b);
      3'b110:  e.res = ~(a | b);
      default: e.res = a | b;
    endcase
    e.z = (e.res == '0);
    return e;
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_quiet(input string tag);
    check({tag, "_busy"},  64'(busy), 64'(0));
    check({tag, "_done"},  64'(done), 64'(0));
    check({tag, "_slice"}, 64'({slice_a, slice_b, slice_c, slice_z0, slice_s}), 64'(0));
  endtask

  // Starts an op at the current negedge, runs it to done and checks everything.
  // poke=1 pulses start with different operands mid-RUN; chain=1 leaves the bench
  // sitting in the DONE cycle so the caller can start the next op back-to-back.
  task automatic do_op(input string tag, input logic [2:0] o, input logic [W-1:0] a,
                       input logic [W-1:0] b, input bit poke, input bit chain);
    exp_t         e;
    logic [W-1:0] a_seen;
    logic [W-1:0] b_seen;
    logic [W-1:0] prev_res;
    bit           got;
    int           lat;
    e        = model(o, a, b);
    prev_res = result;
    op = o; opa = a; opb = b; start = 1'b1;
    a_seen = '0; b_seen = '0; got = 1'b0; lat = 0;
    for (int k = 1; k <= W + 6; k++) begin
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
      if (poke && k == 10) begin
        start = 1'b1; op = ~o; opa = ~a; opb = $urandom;
      end
      if (done) begin got = 1'b1; lat = k; break; end
      if (busy && k <= W) begin
        a_seen[k-1] = slice_a;
        b_seen[k-1] = slice_b;
      end
      if (k == 1) check({tag, "_slice_s"}, 64'(slice_s), 64'(o));
      if (k == 2) check({tag, "_result_held"}, 64'(result), 64'(prev_res));
    end
    check({tag, "_done_seen"}, 64'(got), 64'(1));
    if (got) begin
      check({tag, "_latency"},  64'(lat),       64'(W + 1));
      check({tag, "_bits_a"},   64'(a_seen),    64'(a));
      check({tag, "_bits_b"},   64'(b_seen),    64'(b));
      check({tag, "_result"},   64'(result),    64'(e.res));
      check({tag, "_carry"},    64'(carry_out), 64'(e.c));
      check({tag, "_zero"},     64'(zero),      64'(e.z));
      check({tag, "_overflow"}, 64'(overflow),  64'(e.v));
    end
    if (!chain) begin
      @(posedge clk);
      @(negedge clk);
      check_quiet({tag, "_after"});
      check({tag, "_result_hold"}, 64'(result), 64'(e.res));
    end
  endtask

  initial begin
    #1;
    check("reset_result", 64'(result), 64'(0));
    check("reset_flags", 64'({carry_out, zero, overflow}), 64'(0));
    check_quiet("reset");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check_quiet("idle");

    do_op("add_5_3",   3'b000, 32'd5, 32'd3, 1'b0, 1'b0);
    do_op("sub_5_5",   3'b010, 32'd5, 32'd5, 1'b0, 1'b0);
    do_op("add_wrap",  3'b000, 32'hFFFF_FFFF, 32'd1, 1'b0, 1'b0);
    do_op("add_ovf",   3'b001, 32'h7FFF_FFFF, 32'd1, 1'b0, 1'b0);
    do_op("and_poke",  3'b100, 32'hF0F0_F0F0, 32'hFF00_FF00, 1'b1, 1'b0);
    check("and_value", 64'(result), 64'(32'hF000_F000));
    do_op("sub_borrow", 3'b010, 32'd3, 32'd5, 1'b0, 1'b1);
    do_op("xor_b2b",   3'b011, 32'h1234_5678, 32'h1234_5678, 1'b0, 1'b0);

    // Reset in the middle of RUN: outputs clear immediately and no done follows.
    op = 3'b000; opa = 32'hDEAD_BEEF; opb = 32'h0101_0101; start = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
    end
    check("pre_reset_busy", 64'(busy), 64'(1));
    #2 rst_n = 1'b0;
    #1;
    check("midrst_result", 64'(result), 64'(0));
    check("midrst_flags", 64'({carry_out, zero, overflow}), 64'(0));
    check_quiet("midrst");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    begin
      bit saw_done = 1'b0;
      for (int k = 0; k < W + 4; k++) begin
        @(negedge clk);
        if (done || busy) saw_done = 1'b1;
      end
      check("midrst_no_done", 64'(saw_done), 64'(0));
    end
    do_op("add_1_1", 3'b000, 32'd1, 32'd1, 1'b0, 1'b0);

    for (int i = 0; i < 40; i++) begin
      logic [2:0]   ro;
      logic [W-1:0] ra, rb;
      ro = 3'($urandom_range(0, 7));
      ra = $urandom;
      rb = (i % 5 == 0) ? ra : $urandom;
      do_op($sformatf("rand%0d", i), ro, ra, rb, 1'b0, (i % 2) == 1);
    end
    @(negedge clk);
    @(negedge clk);
    check_quiet("final");

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
